// File: rtl/serial_operand_serializer.sv
// Bit-serial operand transmitter: takes W-bit operand pairs over valid/ready and
// shifts them out LSB-first with first/last markers and a carry-clear strobe.
module serial_operand_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic         out_a,
  output logic         out_b,
  output logic         out_first,
  output logic         out_last,
  output logic         carry_clr
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [W-1:0]  hold_a_p0;
  logic [W-1:0]  hold_b_p0;
  logic          vld_p0;
  logic [W-1:0]  sa_p1;
  logic [W-1:0]  sb_p1;
  logic [CW-1:0] cnt_p1;
  logic          vld_p1;

  logic xfer;
  logic last_bit;
  logic stage_free;

  assign in_ready   = ~vld_p0 & ~rst;
  assign xfer       = in_valid & in_ready;
  assign last_bit   = vld_p1 & (cnt_p1 == CNT_LAST);
  assign stage_free = ~vld_p1 | last_bit;

  assign out_valid = vld_p1;
  assign out_a     = sa_p1[0];
  assign out_b     = sb_p1[0];
  assign out_first = vld_p1 & (cnt_p1 == '0);
  assign out_last  = last_bit;
  assign carry_clr = ~vld_p1 | last_bit;

  // p0 -> p1: hold register feeds the shift stage; the stage reloads on its
  // last bit so consecutive words leave with no idle cycle between them.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
      sa_p1  <= '0;
      sb_p1  <= '0;
    end else if (stage_free) begin
      if (vld_p0) begin
        sa_p1  <= hold_a_p0;
        sb_p1  <= hold_b_p0;
        cnt_p1 <= '0;
        vld_p1 <= 1'b1;
        vld_p0 <= 1'b0;
      end else if (xfer) begin
        sa_p1  <= in_a;
        sb_p1  <= in_b;
        cnt_p1 <= '0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else begin
      sa_p1  <= {1'b0, sa_p1[W-1:1]};
      sb_p1  <= {1'b0, sb_p1[W-1:1]};
      cnt_p1 <= cnt_p1 + 1'b1;
      if (xfer) begin
        vld_p0 <= 1'b1;
      end
    end
  end

  // Hold data carries no reset; only its valid flag matters.
  always_ff @(posedge clk) begin
    if (~rst & ~stage_free & xfer) begin
      hold_a_p0 <= in_a;
      hold_b_p0 <= in_b;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: word-schedule model plus a serial adder
// for W=8, and literal cycle-by-cycle expectations for a W=2 instance.
module tb_serial_operand_serializer;

  localparam int W8 = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       out_valid, out_a, out_b, out_first, out_last, carry_clr;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] in_a2 = '0;
  logic [1:0] in_b2 = '0;
  logic       out_valid2, out_a2, out_b2, out_first2, out_last2, carry_clr2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_operand_serializer #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_a(out_a),
    .out_b(out_b), .out_first(out_first), .out_last(out_last),
    .carry_clr(carry_clr)
  );

  serial_operand_serializer #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_a(out_a2),
    .out_b(out_b2), .out_first(out_first2), .out_last(out_last2),
    .carry_clr(carry_clr2)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: each accepted word starts at max(accept edge, previous start + W)
  // and occupies W consecutive cycles; it sits in the hold from its accept
  // edge up to (not including) its start.
  int         cyc = 0;
  int         st_q[$];
  int         e_q[$];
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  int         last_start = -100;
  logic [7:0] exp_sum[$];
  bit         chk_en = 1'b0;
  int         run = 0;
  int         max_run = 0;
  logic       carry = 1'b0;
  logic [7:0] acc = '0;
  int         acc_idx = 0;

  function automatic bit hold_full(input int c);
    bit f = 1'b0;
    for (int i = 0; i < st_q.size(); i++)
      if (e_q[i] <= c && c < st_q[i]) f = 1'b1;
    return f;
  endfunction

  always @(posedge clk) begin
    int c_prev;
    int s;
    c_prev = cyc;
    cyc = cyc + 1;
    if (rst) begin
      st_q.delete(); e_q.delete(); a_q.delete(); b_q.delete();
      last_start = -100;
    end else if (in_valid && !hold_full(c_prev)) begin
      s = (cyc > last_start + W8) ? cyc : last_start + W8;
      st_q.push_back(s); e_q.push_back(cyc);
      a_q.push_back(in_a); b_q.push_back(in_b);
      last_start = s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit   ev, ef, el, ea, eb;
      logic sbit;
      int   k;
      ev = 0; ef = 0; el = 0; ea = 0; eb = 0;
      for (int i = 0; i < st_q.size(); i++) begin
        if (cyc >= st_q[i] && cyc < st_q[i] + W8) begin
          k  = cyc - st_q[i];
          ev = 1;
          ea = a_q[i][k];
          eb = b_q[i][k];
          ef = (k == 0);
          el = (k == W8 - 1);
        end
      end
      chk("out_valid", out_valid, ev);
      chk("out_first", out_first, ef);
      chk("out_last", out_last, el);
      chk("carry_clr", carry_clr, !ev || el);
      chk("in_ready", in_ready, !hold_full(cyc) && !rst);
      if (ev) begin
        chk("out_a", out_a, ea);
        chk("out_b", out_b, eb);
      end
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      // Downstream serial adder, carry held clear by carry_clr.
      sbit = out_a ^ out_b ^ carry;
      if (out_valid) begin
        if (out_first) begin acc = '0; acc_idx = 0; end
        if (acc_idx < 8) acc[acc_idx] = sbit;
        acc_idx++;
        if (out_last) begin
          if (exp_sum.size() == 0) chk("sum_unexpected", {56'd0, acc}, 64'hDEAD);
          else chk("sum", {56'd0, acc}, {56'd0, exp_sum.pop_front()});
        end
      end
      carry = carry_clr ? 1'b0 : ((out_a & out_b) | (out_a & carry) | (out_b & carry));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] ga, gb;
    logic [3:0] f2, l2, v2;
    logic [1:0] s2a, s2b;
    logic       c2, sb2;
    int         nv;

    // Reset for two cycles.
    step(); step();
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_a", out_a, 1'b0);
    chk("rst_out_b", out_b, 1'b0);
    chk("rst_carry_clr", carry_clr, 1'b1);
    chk("rst_in_ready_rel", in_ready, 1'b1);
    chk_en = 1'b1;
    repeat (4) step();

    // Single pair A5/3C: check bits literally over the 8 cycles after accept.
    exp_sum.push_back(8'hE1);
    send(8'hA5, 8'h3C);
    ga = '0; gb = '0;
    for (int k = 0; k < 8; k++) begin
      ga[k] = out_a; gb[k] = out_b;
      if (k == 0) chk("single_first", out_first, 1'b1);
      if (k == 7) chk("single_last", out_last, 1'b1);
      step();
    end
    chk("single_a_bits", ga, 8'hA5);
    chk("single_b_bits", gb, 8'h3C);
    chk("single_idle_after", out_valid, 1'b0);
    repeat (3) step();

    // Streaming four pairs with in_valid held high.
    max_run = 0;
    exp_sum.push_back(8'h00); exp_sum.push_back(8'h00);
    exp_sum.push_back(8'h00); exp_sum.push_back(8'h80);
    send(8'hFF, 8'h01);
    send(8'h80, 8'h80);
    send(8'h00, 8'h00);
    send(8'h7F, 8'h01);
    repeat (30) step();
    chk("stream_run", max_run, 32);

    // Hold occupancy: second pair offered during bit 2 of word 1.
    exp_sum.push_back(8'h46); exp_sum.push_back(8'hFF);
    send(8'h12, 8'h34);
    step(); step();
    send(8'h0F, 8'hF0);
    chk("hold_in_ready_low", in_ready, 1'b0);
    repeat (4) step();
    chk("hold_w1_last", out_last, 1'b1);
    step();
    chk("hold_w2_first", out_first, 1'b1);
    chk("hold_w2_valid", out_valid, 1'b1);
    chk("hold_in_ready_up", in_ready, 1'b1);
    repeat (12) step();

    // Reset at bit 4 of a word with the hold full.
    send(8'hAA, 8'h55);
    send(8'h11, 8'h22);
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    step();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_carry_clr", carry_clr, 1'b1);
    chk("midrst_in_ready2", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_rel", in_ready, 1'b1);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) nv++;
      step();
    end
    chk("midrst_no_remnant", nv, 0);
    exp_sum.push_back(8'h02);
    send(8'h01, 8'h01);
    repeat (12) step();
    chk("sum_queue_drained", exp_sum.size(), 0);

    // W=2 instance: (3,1) then (2,2) back to back.
    in_valid2 = 1'b1; in_a2 = 2'd3; in_b2 = 2'd1;
    chk("w2_ready_idle", in_ready2, 1'b1);
    step();
    in_a2 = 2'd2; in_b2 = 2'd2;
    f2 = '0; l2 = '0; v2 = '0; s2a = '0; s2b = '0; c2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        chk("w2_ready_hold", in_ready2, 1'b0);
        in_valid2 = 1'b0;
      end
      f2[k] = out_first2; l2[k] = out_last2; v2[k] = out_valid2;
      sb2 = out_a2 ^ out_b2 ^ c2;
      if (k < 2) s2a[k] = sb2; else s2b[k-2] = sb2;
      c2 = carry_clr2 ? 1'b0 : ((out_a2 & out_b2) | (out_a2 & c2) | (out_b2 & c2));
      step();
    end
    chk("w2_valid", v2, 4'b1111);
    chk("w2_first", f2, 4'b0101);
    chk("w2_last", l2, 4'b1010);
    chk("w2_sum0", s2a, 2'd0);
    chk("w2_sum1", s2b, 2'd0);
    chk("w2_idle", out_valid2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Bit-serial operand transmitter placed upstream of the bit-serial adder. It accepts pairs of W-bit parallel operands through a valid/ready handshake and drives them out LSB-first, one bit of each operand per clock. Alongside the bits it generates a carry-clear strobe, so the adder's carry register is zero at bit 0 of every word. Back-to-back words stream with no idle cycle between them.

## Interface
- W, default 8: operand width in bits; legal range 2..64.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair present on in_a/in_b.
- in_ready  out  1  block can take a pair this cycle; a pair transfers on a posedge where in_valid & in_ready.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  out_a/out_b carry a live bit this cycle.
- out_a  out  1  current bit of A, LSB first.
- out_b  out  1  current bit of B, LSB first.
- out_first  out  1  high with bit 0 of a word.
- out_last  out  1  high with bit W-1 of a word.
- carry_clr  out  1  drives the adder's reset: equals ~out_valid | out_last.

## Operation
- Storage:
  - One shift stage holds A/B shift registers, a bit counter of $clog2(W) bits, and a busy flag.
  - One holding register has its own hold_valid flag.
- in_ready = ~hold_valid & ~rst (combinational).
- Outputs are all registered-state derived:
  - out_a = sa[0], out_b = sb[0], out_valid = busy.
  - out_first = busy & (cnt == 0).
  - out_last = busy & (cnt == W-1).
- Each cycle:
  - busy & ~out_last: shift sa/sb right by 1 and increment cnt.
  - Stage free (~busy | out_last):
    - If hold_valid: load hold into the stage and clear hold_valid.
    - Else, if an input transfer occurs: load in_a/in_b directly into the stage; the hold stays empty.
    - Else: busy <= 0.
    - Every load sets cnt <= 0 and busy <= 1.
  - Stage occupied (busy & ~out_last) and an input transfer occurs: capture the pair into hold and set hold_valid.
  - Stage free, hold_valid, and a transfer occurs: impossible, because in_ready = 0 while hold_valid.
- carry_clr high during idle cycles and during the last bit of each word. The adder's carry therefore reads 0 on the following bit 0. Carry-out of bit W-1 is discarded (modulo-2^W sum).
- Serial side has no back-pressure: once busy, one bit leaves every cycle.
- Reset mid-word: the word is abandoned with no partial output after reset. The held pair is dropped.

## Timing
- Reset values:
  - busy = 0, hold_valid = 0, cnt = 0, sa = sb = 0.
  - Outputs: out_valid = out_first = out_last = 0, out_a = out_b = 0, carry_clr = 1, in_ready = 0 while rst high, then 1.
- Latency: a pair accepted at edge T from an idle stage shows bit 0 in cycle T..T+1, i.e. immediately after edge T. Bit k appears k cycles later, and out_last comes W-1 cycles after out_first.
- Throughput: one word per W cycles. With in_valid held high, out_valid stays high continuously and out_first follows out_last in the next cycle.
- in_ready drops the cycle after a pair is captured into hold. It rises the cycle after hold drains, which happens at an out_last edge.
- Simultaneous events:
  - Hold empty, out_last high, and transfer at the same edge: direct load, zero gap.
  - Hold full and out_last: the hold drains into the stage, and in_ready rises next cycle.

## Test plan
- W=8, reset for 2 cycles, then idle: out_valid=0, carry_clr=1, in_ready=1 constantly. Checking the adder's sum output is meaningless here.
- Single pair A=8'hA5, B=8'h3C at edge T:
  - out_a sequence 1,0,1,0,0,1,0,1 and out_b sequence 0,0,1,1,1,1,0,0.
  - out_first in the 1st cycle, out_last in the 8th.
  - Adder output reassembles to 8'hE1.
- Streaming 4 pairs with in_valid held high, (FF,01), (80,80), (00,00), (7F,01):
  - 32 consecutive out_valid cycles, no gaps.
  - Reassembled sums 00, 00, 00, 80, showing carry cleared between words.
  - in_ready pattern: 1, then low except one cycle per word.
- Hold occupancy: offer pair 2 in cycle 3 of word 1. in_ready goes 0 the next cycle, and pair 2's bit 0 follows word 1's bit 7 directly.
- rst asserted at bit 4 of a word with hold full: the next cycle shows out_valid=0, carry_clr=1, in_ready=0. After release, in_ready=1 and no remnant bits appear.
- W=2 parameter: pairs (3,1), (2,2) streamed back-to-back. out_first and out_last alternate every cycle, and the sums are 0 and 0.
